bp_me_host_client: RTL and testbench

Synthesizable BedRock initiator that drives the host device's uncached register map from the core side. It accepts a byte stream and one finish code, and issues one `e_bedrock_mem_uc_wr` per byte to the per-core putch register. It then issues one dword write to the per-core finish register. It keeps at most one request outstanding and checks each `mem_rev` response against the request it sent. It sits between a core-local producer (test harness or accelerator) and the I/O network that reaches the host.

---
 rtl/bp_me_host_client.sv | 140 ++++++++++++++
 tb/tb_bp_me_host_client.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_me_host_client.sv
// bp_me_host_client: BedRock initiator that turns a byte stream plus one finish code into
// uncached writes to the host putch/finish registers, one request outstanding at a time.
module bp_me_host_client #(
  parameter int core_id_p = 0,
  parameter int buf_els_p = 4,
  parameter int paddr_width_p = 40,
  parameter int bedrock_fill_width_p = 64,
  parameter int lce_id_width_p = 8,
  parameter logic [paddr_width_p-1:0] putch_core_match_addr_gp = 'h0010_3000,
  parameter logic [paddr_width_p-1:0] finish_match_addr_gp = 'h0010_2000,
  localparam int mem_fwd_header_width_lp = lce_id_width_p + 3 + paddr_width_p + 4,
  localparam int mem_rev_header_width_lp = mem_fwd_header_width_lp
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic [7:0]                         char_i,
  input  logic                               char_v_i,
  output logic                               char_ready_and_o,
  input  logic [7:0]                         finish_code_i,
  input  logic                               finish_v_i,
  output logic                               finish_ready_and_o,
  output logic [mem_fwd_header_width_lp-1:0] mem_fwd_header_o,
  output logic [bedrock_fill_width_p-1:0]    mem_fwd_data_o,
  output logic                               mem_fwd_v_o,
  input  logic                               mem_fwd_ready_and_i,
  input  logic [mem_rev_header_width_lp-1:0] mem_rev_header_i,
  input  logic [bedrock_fill_width_p-1:0]    mem_rev_data_i,
  input  logic                               mem_rev_v_i,
  output logic                               mem_rev_ready_and_o,
  output logic                               busy_o,
  output logic                               done_o,
  output logic                               err_o
);
  typedef enum logic [1:0] {e_idle, e_send, e_wait, e_done} state_e;
  localparam logic [3:0] uc_wr_lp = 4'd3;
  localparam logic [2:0] size_1_lp = 3'd0;
  localparam logic [2:0] size_8_lp = 3'd3;
  localparam int lg_lp = $clog2(buf_els_p);
  localparam logic [paddr_width_p-1:0] off_lp = paddr_width_p'(core_id_p) << 3;
  localparam logic [lce_id_width_p-1:0] lce_lp = lce_id_width_p'(core_id_p);

  state_e state_q, state_d;
  logic [7:0] buf_q [buf_els_p];
  logic [lg_lp-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [lg_lp:0] cnt_q, cnt_d;
  logic [mem_fwd_header_width_lp-1:0] hdr_q, hdr_d;
  logic [bedrock_fill_width_p-1:0] data_q, data_d;
  logic [7:0] code_q, code_d;
  logic fin_q, fin_d, pend_q, pend_d, done_q, done_d, err_q, err_d;
  logic push, pop, fin_acc, rev_acc, full, empty;
  logic [paddr_width_p-1:0] rev_addr;
  logic [3:0] rev_type;
  logic unused;

  assign empty = cnt_q == '0;
  assign full = cnt_q == (lg_lp+1)'(buf_els_p);
  // Readies are gated by the reset pin so they drop the instant reset asserts
  assign char_ready_and_o = reset_n_i & ~full & ~pend_q & ~done_q;
  assign finish_ready_and_o = reset_n_i & ~pend_q & ~done_q;
  assign mem_rev_ready_and_o = reset_n_i;
  assign push = char_v_i & char_ready_and_o;
  assign fin_acc = finish_v_i & finish_ready_and_o;
  assign rev_acc = mem_rev_v_i & mem_rev_ready_and_o;
  assign pop = (state_q == e_idle) & ~empty;
  assign {rev_addr, rev_type} = mem_rev_header_i[paddr_width_p+3:0];
  assign unused = ^{mem_rev_data_i, mem_rev_header_i[mem_rev_header_width_lp-1:paddr_width_p+4]};
  assign mem_fwd_header_o = hdr_q;
  assign mem_fwd_data_o = data_q;
  assign mem_fwd_v_o = state_q == e_send;
  assign busy_o = (state_q == e_send) | (state_q == e_wait) | ~empty;
  assign done_o = done_q;
  assign err_o = err_q;

  always_comb begin
    state_d = state_q;
    hdr_d = hdr_q;
    data_d = data_q;
    fin_d = fin_q;
    rd_d = rd_q + lg_lp'(pop);
    wr_d = wr_q + lg_lp'(push);
    cnt_d = cnt_q + (lg_lp+1)'(push) - (lg_lp+1)'(pop);
    pend_d = pend_q | fin_acc;
    code_d = fin_acc ? finish_code_i : code_q;
    done_d = done_q;
    err_d = err_q | (rev_acc & (state_q != e_wait));
    case (state_q)
      e_idle:
        if (!empty) begin
          hdr_d = {lce_lp, size_1_lp, putch_core_match_addr_gp + off_lp, uc_wr_lp};
          data_d = {(bedrock_fill_width_p/8){buf_q[rd_q]}};
          fin_d = 1'b0;
          state_d = e_send;
        end else if (pend_q) begin
          hdr_d = {lce_lp, size_8_lp, finish_match_addr_gp + off_lp, uc_wr_lp};
          data_d = {(bedrock_fill_width_p/64){56'b0, code_q}};
          fin_d = 1'b1;
          state_d = e_send;
        end
      e_send: state_d = mem_fwd_ready_and_i ? e_wait : e_send;
      e_wait:
        if (rev_acc) begin
          err_d = err_q | (rev_type != uc_wr_lp) | (rev_addr != hdr_q[paddr_width_p+3:4]);
          state_d = fin_q ? e_done : e_idle;
          done_d = done_q | fin_q;
          pend_d = fin_q ? 1'b0 : pend_q;
        end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state_q <= e_idle;
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
      hdr_q <= '0;
      data_q <= '0;
      code_q <= '0;
      fin_q <= 1'b0;
      pend_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
      hdr_q <= hdr_d;
      data_q <= data_d;
      code_q <= code_d;
      fin_q <= fin_d;
      pend_q <= pend_d;
      done_q <= done_d;
      err_q <= err_d;
    end

  always_ff @(posedge clk_i)
    if (push) buf_q[wr_q] <= char_i;
endmodule

// File: tb/tb_bp_me_host_client.sv
// tb_bp_me_host_client: directed and randomized checks of the host client against a
// request-stream model built from the register-map rules.
module tb_bp_me_host_client;
  localparam int CORE = 3;
  localparam int PW = 40;
  localparam int FW = 64;
  localparam int LW = 8;
  localparam int HW = LW + 3 + PW + 4;
  localparam logic [PW-1:0] PUTCH = 40'h0010_3000;
  localparam logic [PW-1:0] FIN = 40'h0010_2000;

  typedef struct packed {logic [HW-1:0] h; logic [FW-1:0] d;} req_t;

  logic clk = 0, reset_n_i = 0;
  logic [7:0] char_i = 0, finish_code_i = 0;
  logic char_v_i = 0, finish_v_i = 0, mem_fwd_ready_and_i = 0, mem_rev_v_i = 0;
  logic char_ready_and_o, finish_ready_and_o, mem_fwd_v_o, mem_rev_ready_and_o;
  logic busy_o, done_o, err_o;
  logic [HW-1:0] mem_fwd_header_o, mem_rev_header_i = 0;
  logic [FW-1:0] mem_fwd_data_o, mem_rev_data_i = 0;

  int vecs = 0, errs = 0;
  req_t exp_q[$];
  int chk_n = 0;
  bit fin_sent = 0;

  int cap_n = 0;
  logic [HW-1:0] cap_h [512];
  logic [FW-1:0] cap_d [512];
  bit rsp_pend = 0;
  int rsp_wait = 0;
  logic [HW-1:0] rsp_hdr = 0;
  int lat = 0, stall_pct = 0;
  bit stall_force = 0, bad_addr = 0, kill_rsp = 0;
  int inj_req = 0, inj_done = 0;
  bit prev_stall = 0;
  logic [HW-1:0] prev_h = 0;
  logic [FW-1:0] prev_d = 0;

  bp_me_host_client #(.core_id_p(CORE), .buf_els_p(4)) dut (
    .clk_i(clk), .reset_n_i(reset_n_i),
    .char_i(char_i), .char_v_i(char_v_i), .char_ready_and_o(char_ready_and_o),
    .finish_code_i(finish_code_i), .finish_v_i(finish_v_i), .finish_ready_and_o(finish_ready_and_o),
    .mem_fwd_header_o(mem_fwd_header_o), .mem_fwd_data_o(mem_fwd_data_o), .mem_fwd_v_o(mem_fwd_v_o),
    .mem_fwd_ready_and_i(mem_fwd_ready_and_i),
    .mem_rev_header_i(mem_rev_header_i), .mem_rev_data_i(mem_rev_data_i), .mem_rev_v_i(mem_rev_v_i),
    .mem_rev_ready_and_o(mem_rev_ready_and_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(string tag, logic [127:0] got, logic [127:0] want);
    vecs++;
    assert (got === want) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  // Expected request for a putch byte or a finish code, from the register-map rules
  function automatic void expect_req(bit fin, logic [7:0] b);
    req_t r;
    logic [PW-1:0] a;
    a = (fin ? FIN : PUTCH) + PW'(CORE * 8);
    r.h = {LW'(CORE), fin ? 3'd3 : 3'd0, a, 4'd3};
    for (int i = 0; i < FW / 8; i++) r.d[i*8 +: 8] = fin ? ((i % 8) == 0 ? b : 8'h00) : b;
    exp_q.push_back(r);
  endfunction

  task automatic check_reqs(string tag);
    req_t e;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_present"}, 128'(chk_n < cap_n), 128'(1));
      if (chk_n < cap_n) begin
        chk({tag, "_hdr"}, 128'(cap_h[chk_n]), 128'(e.h));
        chk({tag, "_data"}, 128'(cap_d[chk_n]), 128'(e.d));
        chk_n++;
      end
    end
    chk({tag, "_extra"}, 128'(cap_n), 128'(chk_n));
  endtask

  task automatic drain(string tag);
    int n;
    n = 0;
    while ((busy_o || rsp_pend || (fin_sent && !done_o)) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk({tag, "_drain"}, 128'(n < 2000), 128'(1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n_i = 0;
    char_v_i = 0;
    finish_v_i = 0;
    fin_sent = 0;
    repeat (3) @(negedge clk);
    reset_n_i = 1;
    @(negedge clk);
  endtask

  task automatic send_byte(logic [7:0] b);
    int n;
    n = 0;
    char_i = b;
    char_v_i = 1;
    while (!char_ready_and_o && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("char_accept", 128'(n < 500), 128'(1));
    if (char_ready_and_o) expect_req(0, b);
    @(negedge clk);
    char_v_i = 0;
  endtask

  task automatic send_fin(logic [7:0] c);
    int n;
    n = 0;
    finish_code_i = c;
    finish_v_i = 1;
    while (!finish_ready_and_o && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("finish_accept", 128'(n < 500), 128'(1));
    if (finish_ready_and_o) begin
      expect_req(1, c);
      fin_sent = 1;
    end
    @(negedge clk);
    finish_v_i = 0;
  endtask

  // Responder: captures requests, answers after lat cycles, randomly back-pressures
  initial forever begin
    @(negedge clk);
    mem_rev_v_i = 0;
    if (kill_rsp) rsp_pend = 0;
    if (inj_req != inj_done) begin
      inj_done = inj_req;
      mem_rev_v_i = 1;
      mem_rev_header_i = {LW'(CORE), 3'd0, PUTCH + PW'(CORE * 8), 4'd3};
    end else if (rsp_pend) begin
      if (rsp_wait == 0) begin
        mem_rev_v_i = 1;
        mem_rev_header_i = rsp_hdr;
        rsp_pend = 0;
      end else rsp_wait--;
    end
    if (prev_stall && mem_fwd_v_o) begin
      chk("fwd_stable_hdr", 128'(mem_fwd_header_o), 128'(prev_h));
      chk("fwd_stable_data", 128'(mem_fwd_data_o), 128'(prev_d));
    end
    mem_fwd_ready_and_i = !stall_force && ($urandom_range(99) >= stall_pct);
    prev_stall = mem_fwd_v_o && !mem_fwd_ready_and_i;
    prev_h = mem_fwd_header_o;
    prev_d = mem_fwd_data_o;
    if (mem_fwd_v_o && mem_fwd_ready_and_i && !kill_rsp) begin
      if (cap_n < 512) begin
        cap_h[cap_n] = mem_fwd_header_o;
        cap_d[cap_n] = mem_fwd_data_o;
        cap_n++;
      end
      rsp_pend = 1;
      rsp_wait = lat;
      rsp_hdr = mem_fwd_header_o ^ (bad_addr ? HW'(1) << 4 : HW'(0));
    end
  end

  initial begin
    logic [7:0] hello [6];
    int acc, nb, n0;
    hello = '{8'h48, 8'h45, 8'h4c, 8'h4c, 8'h4f, 8'h0a};

    repeat (3) @(negedge clk);
    chk("rst_fwd_v", 128'(mem_fwd_v_o), 128'(0));
    chk("rst_busy_done_err", 128'({busy_o, done_o, err_o}), 128'(0));
    chk("rst_readies", 128'({char_ready_and_o, finish_ready_and_o, mem_rev_ready_and_o}), 128'(0));
    reset_n_i = 1;
    @(negedge clk);
    chk("post_rst_readies", 128'({char_ready_and_o, finish_ready_and_o, mem_rev_ready_and_o}), 128'(3'b111));

    // single byte latency
    char_i = 8'h41;
    char_v_i = 1;
    chk("c0_char_ready", 128'(char_ready_and_o), 128'(1));
    expect_req(0, 8'h41);
    @(negedge clk);
    char_v_i = 0;
    chk("c1_fwd_v", 128'(mem_fwd_v_o), 128'(0));
    chk("c1_busy", 128'(busy_o), 128'(1));
    @(negedge clk);
    chk("c2_fwd_v", 128'(mem_fwd_v_o), 128'(1));
    drain("single");
    chk("single_busy_low", 128'(busy_o), 128'(0));
    chk("single_err", 128'(err_o), 128'(0));
    check_reqs("single");

    // full buffer under back-pressure
    stall_force = 1;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      char_i = acc < 6 ? hello[acc] : 8'h00;
      char_v_i = 1;
      if (acc < 6 && char_ready_and_o) begin
        expect_req(0, hello[acc]);
        acc++;
      end
      @(negedge clk);
    end
    char_v_i = 0;
    chk("stall_accepts", 128'(acc), 128'(5));
    chk("stall_ready_low", 128'(char_ready_and_o), 128'(0));
    stall_force = 0;
    for (int i = acc; i < 6; i++) send_byte(hello[i]);
    drain("hello");
    check_reqs("hello");
    chk("hello_err", 128'(err_o), 128'(0));

    // wrong response address still advances but flags err
    bad_addr = 1;
    send_byte(8'h55);
    drain("badaddr");
    bad_addr = 0;
    chk("badaddr_err", 128'(err_o), 128'(1));
    chk("badaddr_busy", 128'(busy_o), 128'(0));
    check_reqs("badaddr");

    // unexpected response in idle
    do_reset();
    chk("inj_err_pre", 128'(err_o), 128'(0));
    inj_req++;
    repeat (4) @(negedge clk);
    chk("inj_err", 128'(err_o), 128'(1));
    chk("inj_no_req", 128'({mem_fwd_v_o, 32'(cap_n)}), 128'({1'b0, 32'(chk_n)}));

    // asynchronous reset while waiting for a response
    do_reset();
    lat = 10;
    n0 = cap_n;
    send_byte(8'h33);
    for (int i = 0; i < 200 && cap_n == n0; i++) @(negedge clk);
    @(negedge clk);
    check_reqs("prewait");
    kill_rsp = 1;
    #2 reset_n_i = 0;
    #1;
    chk("arst_fwd_busy", 128'({mem_fwd_v_o, busy_o}), 128'(0));
    chk("arst_readies", 128'({char_ready_and_o, finish_ready_and_o, mem_rev_ready_and_o}), 128'(0));
    chk("arst_done_err", 128'({done_o, err_o}), 128'(0));
    repeat (3) @(negedge clk);
    reset_n_i = 1;
    @(negedge clk);
    kill_rsp = 0;
    lat = 0;
    send_byte(8'h7a);
    drain("post_arst");
    check_reqs("post_arst");
    chk("post_arst_err", 128'(err_o), 128'(0));

    // bytes then finish, byte and finish accepted together
    char_i = 8'h61;
    char_v_i = 1;
    chk("ab_a_ready", 128'(char_ready_and_o), 128'(1));
    expect_req(0, 8'h61);
    @(negedge clk);
    char_i = 8'h62;
    finish_code_i = 8'h00;
    finish_v_i = 1;
    chk("ab_b_fin_ready", 128'({char_ready_and_o, finish_ready_and_o}), 128'(2'b11));
    expect_req(0, 8'h62);
    expect_req(1, 8'h00);
    fin_sent = 1;
    @(negedge clk);
    finish_v_i = 0;
    char_i = 8'h63;
    chk("ab_pend_blocks_char", 128'(char_ready_and_o), 128'(0));
    drain("finish");
    chk("finish_done", 128'(done_o), 128'(1));
    chk("finish_err", 128'(err_o), 128'(0));
    check_reqs("finish");
    repeat (10) @(negedge clk);
    chk("done_readies", 128'({char_ready_and_o, finish_ready_and_o}), 128'(0));
    chk("done_no_req", 128'({mem_fwd_v_o, 32'(cap_n)}), 128'({1'b0, 32'(chk_n)}));
    char_v_i = 0;

    // randomized streams
    for (int r = 0; r < 6; r++) begin
      do_reset();
      stall_pct = $urandom_range(60);
      lat = $urandom_range(5);
      nb = $urandom_range(12, 1);
      for (int i = 0; i < nb; i++) begin
        repeat ($urandom_range(2)) @(negedge clk);
        send_byte(8'($urandom));
      end
      send_fin(8'($urandom));
      drain("rnd");
      chk("rnd_done", 128'(done_o), 128'(1));
      chk("rnd_err", 128'(err_o), 128'(0));
      check_reqs("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
